aes_sub_bytes_seq: RTL and testbench

AES_SUB_BYTES_SEQ -- requirements
Module: aes_sub_bytes_seq

---
 rtl/aes_sub_bytes_seq_pkg.sv | 21 ++
 rtl/aes_sub_bytes_seq_sbox.sv | 34 +++
 rtl/aes_sub_bytes_seq.sv | 122 ++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared constants and FSM encoding for the sequential AES SubBytes block.
package aes_sub_bytes_seq_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_BYTES   = AES_STATE_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Group counter width; a single-group configuration still keeps one bit.
    function automatic int cnt_width(input int lanes);
        int groups;
        groups = AES_BYTES / lanes;
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/aes_sub_bytes_seq_sbox.sv
// Forward AES S-box (FIPS-197), purely combinational; encrypt-side twin of the inverse table.
module aes_sbox
    import aes_sub_bytes_seq_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] a,
    output logic [AES_BYTE_W-1:0] y
);

    // Row r of the table holds S(r0)..S(rF), first entry in the top byte.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base_s;

    assign base_s = 11'd2047 - {a, 3'b000};
    assign y      = FWD_TABLE[base_s -: 8];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes per cycle over 16/LANES cycles
// with a valid/ready handshake on both sides.
module aes_sub_bytes_seq
    import aes_sub_bytes_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int              K        = AES_BYTES / LANES;
    localparam int              CNT_W    = cnt_width(LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    fsm_state_e             fsm_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [AES_STATE_W-1:0] blk_r;
    logic [AES_STATE_W-1:0] blk_next_s;
    logic [AES_STATE_W-1:0] out_state_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic [AES_BYTE_W-1:0]  sb_in_s  [LANES];
    logic [AES_BYTE_W-1:0]  sb_out_s [LANES];

    // Byte k of the state lives at bits [127-8k -: 8]; group c covers bytes c*LANES.. .
    function automatic logic [3:0] byte_idx(input logic [CNT_W-1:0] c, input int l);
        return 4'(int'(c) * LANES + l);
    endfunction

    // Lane multiplexer: feed the cnt-th byte group into the S-box lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sb_in_s[l] = blk_r[{~byte_idx(cnt_r, l), 3'b111} -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .a (sb_in_s[g]),
            .y (sb_out_s[g])
        );
    end

    // Working state with the current group replaced by its substituted bytes.
    always_comb begin
        blk_next_s = blk_r;
        for (int l = 0; l < LANES; l++) begin
            blk_next_s[{~byte_idx(cnt_r, l), 3'b111} -: 8] = sb_out_s[l];
        end
    end

    // Control FSM, working register and all registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            blk_r       <= {AES_STATE_W{1'b0}};
            out_state_r <= {AES_STATE_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        blk_r      <= in_state;
                        cnt_r      <= {CNT_W{1'b0}};
                        fsm_r      <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    blk_r <= blk_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        fsm_r       <= ST_DONE;
                        out_state_r <= blk_next_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_r       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_state = out_state_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq at LANES = 1, 4 and 16, checked against an
// arithmetic (GF(2^8) inverse + affine) S-box and a transaction-level timing model.
module tb_aes_sub_bytes_seq;

    localparam logic [127:0] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SEQ_IN = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [3];
    logic         ir   [3];
    logic [127:0] is   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] os   [3];
    logic         bsy  [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // model state per DUT (0: LANES=1, 1: LANES=4, 2: LANES=16)
    logic         up_r   [3];
    logic         have_r [3];
    logic [127:0] res_r  [3];
    int           age_r  [3];
    logic [127:0] blks   [6];

    always #5 clk = ~clk;

    aes_sub_bytes_seq #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(is[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]), .busy(bsy[0]));
    aes_sub_bytes_seq #(.LANES(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(is[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]), .busy(bsy[1]));
    aes_sub_bytes_seq #(.LANES(16)) u_dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(is[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]), .busy(bsy[2]));

    function automatic int kof(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] x);
        logic [127:0] y = 128'h0;
        for (int k = 0; k < 16; k++) y[127-8*k -: 8] = sbox_ref(x[127-8*k -: 8]);
        return y;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: accept when idle, result visible K edges later, leave on out_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                up_r[d]   <= 1'b0;
                have_r[d] <= 1'b0;
                age_r[d]  <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                up_r[d] <= 1'b1;
                if (!have_r[d]) begin
                    if (up_r[d] && iv[d]) begin
                        have_r[d] <= 1'b1;
                        res_r[d]  <= sub_state(is[d]);
                        age_r[d]  <= 0;
                    end
                end else if (age_r[d] < kof(d)) begin
                    age_r[d] <= age_r[d] + 1;
                end else if (ordy[d]) begin
                    have_r[d] <= 1'b0;
                end
            end
        end
    end

    // Compare every DUT against the model on every falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d in_ready", d), 128'(ir[d]), 128'(up_r[d] && !have_r[d]));
            chk($sformatf("dut%0d out_valid", d), 128'(ov[d]),
                128'(have_r[d] && (age_r[d] == kof(d))));
            chk($sformatf("dut%0d busy", d), 128'(bsy[d]), 128'(have_r[d]));
            if (!rst_n) chk($sformatf("dut%0d reset out_state", d), os[d], 128'h0);
            else if (have_r[d] && (age_r[d] == kof(d)))
                chk($sformatf("dut%0d out_state", d), os[d], res_r[d]);
        end
    end

    task automatic send(input int d, input logic [127:0] data);
        int t = 0;
        while (!ir[d] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("dut%0d send ready", d), 128'(ir[d]), 128'(1'b1));
        iv[d] = 1'b1;
        is[d] = data;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        is[d] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(input int d, input logic [127:0] exp, input string nm, input int lat);
        int n = 0;
        while (!ov[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'(lat));
        chk({nm, " data"}, os[d], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            is[d] = 128'h0;
            ordy[d] = 1'b1;
        end

        // pin the reference model to hand-computed values
        chk("ref S(00)", 128'(sbox_ref(8'h00)), 128'h63);
        chk("ref S(01)", 128'(sbox_ref(8'h01)), 128'h7c);
        chk("ref S(53)", 128'(sbox_ref(8'h53)), 128'hed);
        chk("ref S(ff)", 128'(sbox_ref(8'hff)), 128'h16);
        chk("ref round1", sub_state(R1_IN), R1_OUT);
        chk("ref seq", sub_state(SEQ_IN), SEQ_OUT);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready before first edge", 128'(ir[1]), 128'(1'b0));
        @(posedge clk); #1;
        chk("in_ready after first edge", 128'(ir[1]), 128'(1'b1));

        send(1, 128'h0);
        wait_out(1, {16{8'h63}}, "zero block", 4);

        for (int d = 0; d < 3; d++) begin
            send(d, R1_IN);
            wait_out(d, R1_OUT, $sformatf("round1 dut%0d", d), kof(d));
        end

        // back-pressure: result held, new input ignored
        ordy[1] = 1'b0;
        send(1, R1_IN);
        wait_out(1, R1_OUT, "hold", 4);
        for (int i = 0; i < 10; i++) begin
            iv[1] = 1'b1;
            is[1] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("hold out_state", os[1], R1_OUT);
            chk("hold out_valid", 128'(ov[1]), 128'(1'b1));
            chk("hold in_ready", 128'(ir[1]), 128'(1'b0));
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid", 128'(ov[1]), 128'(1'b0));
        chk("release in_ready", 128'(ir[1]), 128'(1'b1));

        // reset in the second RUN cycle discards the block
        send(1, 128'hdeadbeef0123456789abcdeffedcba98);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 128'(ov[1]), 128'(1'b0));
        chk("abort busy", 128'(bsy[1]), 128'(1'b0));
        chk("abort in_ready", 128'(ir[1]), 128'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort no output", 128'(ov[1]), 128'(1'b0));
        end
        send(1, SEQ_IN);
        wait_out(1, SEQ_OUT, "after abort", 4);

        // back-to-back streaming, in_valid held high
        begin
            int idx = 0, nov = 0, last_c = 0;
            logic prev = 1'b0;
            for (int i = 0; i < 6; i++) blks[i] = {16{8'(8'h11 * i + 8'h05)}} ^ {4{32'(i) << 8}};
            for (int t = 0; t < 80 && nov < 6; t++) begin
                if (prev) idx++;
                if (ov[1]) begin
                    chk("stream order", os[1], sub_state(blks[nov]));
                    if (nov > 0) chk("stream period", 128'(cyc - last_c), 128'(6));
                    last_c = cyc;
                    nov++;
                end
                iv[1] = (idx < 6);
                if (idx < 6) is[1] = blks[idx];
                prev = ir[1] && (idx < 6);
                @(posedge clk); #1;
            end
            iv[1] = 1'b0;
            chk("stream count", 128'(nov), 128'(6));
        end
        repeat (2) @(posedge clk);
        #1;

        // every byte value through the LANES=4 instance
        for (int i = 0; i < 16; i++) begin
            logic [127:0] x;
            for (int j = 0; j < 16; j++) x[127-8*j -: 8] = 8'(16 * i + j);
            send(1, x);
            wait_out(1, sub_state(x), $sformatf("exhaustive %0d", i), 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
